// File: rtl/clock_divider_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_if
// Description : Control/status bundle between a divider client and the
//               clock-enable divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_divider_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] div;
  logic             tick;
  logic             clk_out;
  logic [WIDTH-1:0] count;
  logic             pending;

  modport master (
    output en, load, div,
    input  tick, clk_out, count, pending
  );

  modport slave (
    input  en, load, div,
    output tick, clk_out, count, pending
  );
endinterface
`default_nettype wire

// File: rtl/clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider
// Description : Programmable clock-enable divider with TICK strobe, registered
//               divided clock and period-boundary divisor updates.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  clock_divider_if.slave  bus
);

  localparam logic [WIDTH-1:0] C_RESET_DIV = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);
  localparam logic [WIDTH:0]   C_ONE_WIDE  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_act;
  logic [WIDTH-1:0] r_div_pend;
  logic             r_pending;
  logic             r_tick;
  logic             r_clk_out;

  logic [WIDTH-1:0] w_n;
  logic             w_wrap;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0] w_n_next;
  logic [WIDTH:0]   w_h_next;

  always_comb begin
    w_n        = (r_div_act == '0) ? C_ONE : r_div_act;
    w_wrap     = (r_cnt == (w_n - C_ONE));
    w_cnt_next = w_wrap ? '0 : (r_cnt + C_ONE);

    // A pending divisor is only promoted on a wrap, so the period in flight
    // always finishes with the divisor it started with.
    w_div_next = r_div_act;
    if (!bus.en && bus.load) begin
      w_div_next = bus.div;
    end else if (bus.en && w_wrap && r_pending) begin
      w_div_next = r_div_pend;
    end

    w_n_next = (w_div_next == '0) ? C_ONE : w_div_next;
    w_h_next = ({1'b0, w_n_next} + C_ONE_WIDE) >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_div_act  <= C_RESET_DIV;
      r_div_pend <= '0;
      r_pending  <= 1'b0;
      r_tick     <= 1'b0;
      r_clk_out  <= 1'b0;
    end else begin
      r_div_act <= w_div_next;
      if (bus.en) begin
        r_cnt     <= w_cnt_next;
        r_tick    <= w_wrap;
        r_clk_out <= ({1'b0, w_cnt_next} < w_h_next);
        if (bus.load) begin
          r_div_pend <= bus.div;
          r_pending  <= 1'b1;
        end else if (w_wrap) begin
          r_pending  <= 1'b0;
        end
      end else begin
        r_cnt     <= '0;
        r_tick    <= 1'b0;
        r_clk_out <= 1'b0;
        if (bus.load) begin
          r_pending <= 1'b0;
        end
      end
    end
  end

  assign bus.tick    = r_tick;
  assign bus.clk_out = r_clk_out;
  assign bus.count   = r_cnt;
  assign bus.pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_clock_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_divider
// Description : Randomized scoreboard bench for clock_divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider;

  localparam int W  = 8;
  localparam int RD = 2;

  logic clk;
  logic rst_n;

  clock_divider_if #(.WIDTH(W)) bus ();

  clock_divider #(.WIDTH(W), .RESET_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected {tick, clk_out, count, pending}
  logic [W+2:0] exp_q[$];

  // Reference model: position within the current period and divisor state.
  int m_phase;
  int m_act;
  int m_pend;
  bit m_pv;
  bit m_tick;
  bit m_clk;

  function automatic int eff_n(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [W+2:0] observed();
    return {bus.tick, bus.clk_out, bus.count, bus.pending};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_act = RD; m_pend = 0; m_pv = 0; m_tick = 0; m_clk = 0;
  endtask

  // One clock edge: drive inputs at negedge and queue the post-edge outputs.
  task automatic step(input bit r, input bit e, input bit l, input int d);
    int n;
    @(negedge clk);
    rst_n    = r;
    bus.en   = e;
    bus.load = l;
    bus.div  = W'(d);
    if (!r) begin
      model_reset();
    end else if (e) begin
      n = eff_n(m_act);
      m_phase = m_phase + 1;
      m_tick  = (m_phase == n);
      if (m_tick) begin
        m_phase = 0;
        if (m_pv) begin
          m_act = m_pend;
          m_pv  = 0;
        end
      end
      if (l) begin
        m_pend = d;
        m_pv   = 1;
      end
      m_clk = (m_phase < (eff_n(m_act) + 1) / 2);
    end else begin
      m_phase = 0; m_tick = 0; m_clk = 0;
      if (l) begin
        m_act = d;
        m_pv  = 0;
      end
    end
    exp_q.push_back({m_tick, m_clk, W'(m_phase), m_pv});
  endtask

  // Monitor: DUT presents a fresh output after every rising edge.
  initial begin
    logic [W+2:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs{tick,clk_out,count,pending}", int'(observed()), int'(e));
      end
    end
  end

  initial begin
    int d;
    bit e, l, r;
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.load = 1'b0;
    bus.div  = '0;
    model_reset();
    #3;
    check("reset_state", int'(observed()), 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // Default N=2
    repeat (6) step(1, 1, 0, 0);
    // Load 5 while idle, then run three periods
    step(1, 0, 1, 5);
    repeat (15) step(1, 1, 0, 0);
    // N=4: load 3 mid-period
    step(1, 0, 0, 0);
    step(1, 0, 1, 4);
    step(1, 1, 0, 0);
    step(1, 1, 1, 3);
    repeat (10) step(1, 1, 0, 0);
    // N=4: two loads in one period, last wins
    step(1, 0, 1, 4);
    step(1, 1, 1, 6);
    step(1, 1, 1, 2);
    repeat (8) step(1, 1, 0, 0);
    // Load on the wrap edge
    step(1, 0, 1, 3);
    step(1, 1, 0, 0);
    step(1, 1, 1, 5);
    step(1, 1, 1, 4);
    repeat (14) step(1, 1, 0, 0);
    // DIV=0 and DIV=1 behave as N=1
    step(1, 0, 1, 0);
    repeat (4) step(1, 1, 0, 0);
    step(1, 0, 1, 1);
    repeat (4) step(1, 1, 0, 0);
    // Maximum divisor
    step(1, 0, 1, 255);
    repeat (300) step(1, 1, 0, 0);
    // Async reset mid-period: N=5, cnt=3, pending set
    step(1, 0, 1, 5);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 7);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", int'(observed()), 0);
    step(0, 1, 0, 0);
    repeat (8) step(1, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      r = ($urandom_range(0, 499) != 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255))
                                       : int'($urandom_range(0, 9));
      step(r, e, l, d);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
